// File: rtl/sccb_pkg.sv
// Purpose: shared types and constants for the SCCB responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sccb_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ID,
        ID_ACK,
        SUB,
        SUB_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_NA,
        IGNORE
    } sccb_state_t;

    localparam int SCCB_BITS = 8;
    localparam int ACK_BIT   = 8;

    localparam logic [7:0] SCCB_DEF_ADDR = 8'h42;

endpackage

// File: rtl/sccb_line_sync.sv
// Purpose: synchronize SIOC/SIOD and flag clock edges plus START/STOP conditions.
// Latency: events are reported 3 clk after the pin changes (2 sync stages + history).
// Backpressure: none; events are single-cycle pulses the consumer must take.
module sccb_line_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sioc,
    input  logic i_siod,
    output logic o_sioc_rise,
    output logic o_sioc_fall,
    output logic o_start_det,
    output logic o_stop_det,
    output logic o_siod
);

    // [0],[1] are the synchronizer, [2] is the history stage for edge detection
    logic [2:0] r_sioc;
    logic [2:0] r_siod;

    // Shift both lines through synchronizer + history; idle bus is high
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sioc <= 3'b111;
            r_siod <= 3'b111;
        end else begin
            r_sioc <= {r_sioc[1:0], i_sioc};
            r_siod <= {r_siod[1:0], i_siod};
        end
    end

    // START/STOP need SIOC stable high across the SIOD edge, so a simultaneous
    // change of both lines is left to the data-bit path.
    assign o_sioc_rise = r_sioc[1] & ~r_sioc[2];
    assign o_sioc_fall = ~r_sioc[1] & r_sioc[2];
    assign o_start_det = r_sioc[1] & r_sioc[2] & ~r_siod[1] & r_siod[2];
    assign o_stop_det  = r_sioc[1] & r_sioc[2] & r_siod[1] & ~r_siod[2];
    assign o_siod      = r_siod[1];

endmodule

// File: rtl/sccb_slave.sv
// Purpose: SCCB camera-side responder exposing a register-file port (OV7670 emulation).
// Latency: decode 3 clk after pin edges; reg_we 1 clk after the synchronized 8th SIOC rise.
// Backpressure: none; master-paced bus, reg_rdata must be valid 2 clk after reg_addr moves.
import sccb_pkg::*;

module sccb_slave #(
    parameter logic [7:0] CAMERA_ADDR = SCCB_DEF_ADDR,
    parameter bit         ACK_EN      = 1'b1,
    parameter bit         AUTO_INC    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sioc_i,
    input  logic       siod_i,
    output logic       siod_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       xfer_err
);

    localparam logic [3:0] LAST_BIT = 4'(SCCB_BITS - 1);
    localparam logic [3:0] ACK_SLOT = 4'(ACK_BIT);

    logic w_sioc_rise, w_sioc_fall, w_start_det, w_stop_det, w_siod;

    sccb_line_sync u_sync (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_sioc      (sioc_i),
        .i_siod      (siod_i),
        .o_sioc_rise (w_sioc_rise),
        .o_sioc_fall (w_sioc_fall),
        .o_start_det (w_start_det),
        .o_stop_det  (w_stop_det),
        .o_siod      (w_siod)
    );

    // r_bitcnt counts bits completed by a SIOC fall; r_pend marks a bit sampled
    // on a rise but not yet closed by its fall, so the rise that precedes a
    // START/STOP never counts as a partial byte.
    sccb_state_t r_state, w_state_nxt;
    logic [3:0]  r_bitcnt, w_bitcnt_nxt;
    logic        r_pend, w_pend_nxt;
    logic [6:0]  r_rx, w_rx_nxt;
    logic [6:0]  r_tx, w_tx_nxt;
    logic        r_rd, w_rd_nxt;
    logic        r_nack, w_nack_nxt;
    logic        r_oe, w_oe_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_err, w_err_nxt;
    logic        r_we, w_we_nxt;
    logic [7:0]  r_addr, w_addr_nxt;
    logic [7:0]  r_wdata, w_wdata_nxt;
    logic [7:0]  w_byte;

    assign w_byte = {r_rx, w_siod};

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_bitcnt <= 4'd0;
            r_pend   <= 1'b0;
            r_rx     <= 7'd0;
            r_tx     <= 7'd0;
            r_rd     <= 1'b0;
            r_nack   <= 1'b0;
            r_oe     <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= 8'd0;
            r_wdata  <= 8'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_pend   <= w_pend_nxt;
            r_rx     <= w_rx_nxt;
            r_tx     <= w_tx_nxt;
            r_rd     <= w_rd_nxt;
            r_nack   <= w_nack_nxt;
            r_oe     <= w_oe_nxt;
            r_busy   <= w_busy_nxt;
            r_err    <= w_err_nxt;
            r_we     <= w_we_nxt;
            r_addr   <= w_addr_nxt;
            r_wdata  <= w_wdata_nxt;
        end
    end

    // Next-state and output decode driven by synchronized line events
    always_comb begin
        w_state_nxt  = r_state;
        w_bitcnt_nxt = r_bitcnt;
        w_pend_nxt   = r_pend;
        w_rx_nxt     = r_rx;
        w_tx_nxt     = r_tx;
        w_rd_nxt     = r_rd;
        w_nack_nxt   = r_nack;
        w_oe_nxt     = r_oe;
        w_busy_nxt   = r_busy;
        w_err_nxt    = 1'b0;
        w_we_nxt     = 1'b0;
        w_addr_nxt   = r_addr;
        w_wdata_nxt  = r_wdata;

        // Pointer advances the cycle after each write strobe
        if (r_we && AUTO_INC) begin
            w_addr_nxt = r_addr + 8'd1;
        end

        if (w_start_det || w_stop_det) begin
            w_state_nxt  = w_start_det ? ID : IDLE;
            w_busy_nxt   = w_start_det;
            w_err_nxt    = (r_bitcnt != 4'd0);
            w_bitcnt_nxt = 4'd0;
            w_pend_nxt   = 1'b0;
            w_oe_nxt     = 1'b0;
        end else begin
            case (r_state)
                ID, SUB, WDATA: begin
                    if (w_sioc_rise) begin
                        w_rx_nxt = w_byte[6:0];
                        if (r_bitcnt == LAST_BIT) begin
                            w_bitcnt_nxt = ACK_SLOT;
                            w_pend_nxt   = 1'b0;
                            case (r_state)
                                ID: begin
                                    if (w_byte == CAMERA_ADDR) begin
                                        w_state_nxt = ID_ACK;
                                        w_rd_nxt    = 1'b0;
                                    end else if (w_byte == (CAMERA_ADDR | 8'h01)) begin
                                        w_state_nxt = ID_ACK;
                                        w_rd_nxt    = 1'b1;
                                    end else begin
                                        w_state_nxt  = IGNORE;
                                        w_bitcnt_nxt = 4'd0;
                                    end
                                end
                                SUB: begin
                                    w_addr_nxt  = w_byte;
                                    w_state_nxt = SUB_ACK;
                                end
                                default: begin
                                    w_we_nxt    = 1'b1;
                                    w_wdata_nxt = w_byte;
                                    w_state_nxt = WDATA_ACK;
                                end
                            endcase
                        end else begin
                            w_pend_nxt = 1'b1;
                        end
                    end else if (w_sioc_fall && r_pend) begin
                        w_bitcnt_nxt = r_bitcnt + 4'd1;
                        w_pend_nxt   = 1'b0;
                    end
                end

                ID_ACK, SUB_ACK, WDATA_ACK: begin
                    if (w_sioc_rise) begin
                        w_bitcnt_nxt = 4'd0;
                    end else if (w_sioc_fall) begin
                        if (r_bitcnt == ACK_SLOT) begin
                            w_oe_nxt = ACK_EN;
                        end else begin
                            w_oe_nxt = 1'b0;
                            case (r_state)
                                ID_ACK: begin
                                    if (r_rd) begin
                                        w_state_nxt = RDATA;
                                        w_tx_nxt    = reg_rdata[6:0];
                                        w_oe_nxt    = ~reg_rdata[7];
                                    end else begin
                                        w_state_nxt = SUB;
                                    end
                                end
                                SUB_ACK: w_state_nxt = WDATA;
                                default: w_state_nxt = AUTO_INC ? WDATA : IGNORE;
                            endcase
                        end
                    end
                end

                RDATA: begin
                    if (w_sioc_rise) begin
                        if (r_bitcnt == LAST_BIT) begin
                            w_state_nxt  = RDATA_NA;
                            w_bitcnt_nxt = ACK_SLOT;
                            w_pend_nxt   = 1'b0;
                        end else begin
                            w_pend_nxt = 1'b1;
                        end
                    end else if (w_sioc_fall && r_pend) begin
                        w_bitcnt_nxt = r_bitcnt + 4'd1;
                        w_pend_nxt   = 1'b0;
                        w_oe_nxt     = ~r_tx[6];
                        w_tx_nxt     = {r_tx[5:0], 1'b0};
                    end
                end

                RDATA_NA: begin
                    if (w_sioc_rise) begin
                        w_nack_nxt   = w_siod;
                        w_bitcnt_nxt = 4'd0;
                    end else if (w_sioc_fall) begin
                        if (r_bitcnt == ACK_SLOT) begin
                            w_oe_nxt = 1'b0;
                        end else if (r_nack) begin
                            w_state_nxt = IGNORE;
                        end else begin
                            w_state_nxt = RDATA;
                            w_tx_nxt    = reg_rdata[6:0];
                            w_oe_nxt    = ~reg_rdata[7];
                        end
                    end
                end

                default: begin
                    w_oe_nxt = 1'b0;
                end
            endcase
        end
    end

    assign siod_oe   = r_oe;
    assign reg_addr  = r_addr;
    assign reg_wdata = r_wdata;
    assign reg_we    = r_we;
    assign busy      = r_busy;
    assign xfer_err  = r_err;

endmodule

// File: tb/tb_sccb_slave.sv
// Purpose: randomized self-checking bench for sccb_slave against a register-bank model.
// Latency: master bit period is 20 clk (16x+ oversampling satisfied).
// Backpressure: n/a; the bench plays both SCCB master and external register file.
module tb_sccb_slave;

    localparam int Q = 50;  // quarter of an SCCB bit period, 5 clk

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       sioc = 1'b1;
    logic       sda  = 1'b1;
    logic       siod_i;
    logic       siod_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic       reg_we;
    logic       busy;
    logic       xfer_err;

    logic [7:0]  regfile [256];   // external register file attached to the DUT
    logic [7:0]  mem     [256];   // reference model of the register bank
    logic [7:0]  m_ptr;           // reference model of the sub-address pointer
    logic [7:0]  wd      [4];     // data bytes for the next write transaction
    logic [15:0] wr_log  [$];
    logic [15:0] exp_wr  [$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          err_cnt     = 0;
    int          oe_cnt      = 0;

    always #5 clk = ~clk;

    // Open-drain SIOD: low if either side pulls low
    assign siod_i    = sda & ~siod_oe;
    assign reg_rdata = regfile[reg_addr];

    sccb_slave dut (
        .clk       (clk),
        .rst       (rst),
        .sioc_i    (sioc),
        .siod_i    (siod_i),
        .siod_oe   (siod_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_rdata (reg_rdata),
        .busy      (busy),
        .xfer_err  (xfer_err)
    );

    always @(posedge clk) begin
        if (reg_we) begin
            regfile[reg_addr] <= reg_wdata;
            wr_log.push_back({reg_addr, reg_wdata});
        end
        if (xfer_err) err_cnt++;
        if (siod_oe)  oe_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_bit(input logic b, output logic seen, output logic oe_seen);
        sda = b;
        #Q sioc = 1'b1;
        #Q;
        seen    = siod_i;
        oe_seen = siod_oe;
        #Q sioc = 1'b0;
        #Q;
    endtask

    task automatic m_start;
        sda = 1'b1;
        #Q sioc = 1'b1;
        #Q sda  = 1'b0;
        #Q sioc = 1'b0;
        #Q;
    endtask

    task automatic m_stop;
        sda = 1'b0;
        #Q sioc = 1'b1;
        #Q sda  = 1'b1;
        #(3 * Q);
    endtask

    // Returns the level seen in the 9th (acknowledge) slot
    task automatic m_wbyte(input logic [7:0] d, output logic ack);
        logic s, o;
        for (int i = 7; i >= 0; i--) m_bit(d[i], s, o);
        m_bit(1'b1, ack, o);
    endtask

    task automatic m_rbyte(input bit last, output logic [7:0] d, output logic na_oe);
        logic s, o;
        for (int i = 7; i >= 0; i--) begin
            m_bit(1'b1, s, o);
            d[i] = s;
        end
        m_bit(last ? 1'b1 : 1'b0, s, na_oe);
    endtask

    // Write phase: ID, sub-address, n data bytes; model updates bank and pointer
    task automatic do_write(input logic [7:0] sub, input int n, input bit do_stop);
        logic a;
        m_start;
        m_wbyte(8'h42, a);
        check_eq("id_ack", a, 1'b0);
        check_eq("busy_in_txn", busy, 1'b1);
        m_wbyte(sub, a);
        check_eq("sub_ack", a, 1'b0);
        m_ptr = sub;
        for (int i = 0; i < n; i++) begin
            m_wbyte(wd[i], a);
            check_eq("data_ack", a, 1'b0);
            exp_wr.push_back({m_ptr, wd[i]});
            mem[m_ptr] = wd[i];
            m_ptr = m_ptr + 8'd1;
        end
        if (do_stop) m_stop;
    endtask

    // Read phase: (repeated) START, read ID, n bytes, NA on the last, STOP
    task automatic do_read(input int n);
        logic       a, na_oe;
        logic [7:0] d;
        m_start;
        m_wbyte(8'h43, a);
        check_eq("rd_id_ack", a, 1'b0);
        for (int i = 0; i < n; i++) begin
            m_rbyte(i == n - 1, d, na_oe);
            check_eq("rd_data", d, mem[m_ptr]);
            check_eq("rd_na_oe", na_oe, 1'b0);
        end
        m_stop;
    endtask

    task automatic check_log;
        #(2 * Q);
        check_eq("wr_count", wr_log.size(), exp_wr.size());
        while (exp_wr.size() > 0 && wr_log.size() > 0)
            check_eq("wr_entry", wr_log.pop_front(), exp_wr.pop_front());
        wr_log.delete();
        exp_wr.delete();
    endtask

    initial begin
        logic a, s, o;
        for (int i = 0; i < 256; i++) begin
            regfile[i] = 8'($urandom);
            mem[i]     = regfile[i];
        end
        m_ptr = 8'h00;

        // Reset values
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_eq("rst_oe",    siod_oe,   1'b0);
        check_eq("rst_addr",  reg_addr,  8'h00);
        check_eq("rst_wdata", reg_wdata, 8'h00);
        check_eq("rst_we",    reg_we,    1'b0);
        check_eq("rst_busy",  busy,      1'b0);
        check_eq("rst_err",   xfer_err,  1'b0);
        rst = 1'b0;
        #(4 * Q);

        // 3-phase write 42/12/80
        err_cnt = 0;
        wd[0] = 8'h80;
        do_write(8'h12, 1, 1'b1);
        check_log;
        check_eq("wr_busy_after_stop", busy, 1'b0);
        check_eq("wr_no_err", err_cnt, 0);

        // Write 42/0A, repeated START, read 43 returning 8'h76
        regfile[8'h0A] = 8'h76;
        mem[8'h0A]     = 8'h76;
        do_write(8'h0A, 0, 1'b0);
        do_read(1);
        check_log;
        check_eq("rd_no_err", err_cnt, 0);

        // Auto-increment with 8-bit wrap
        wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33;
        do_write(8'hFE, 3, 1'b1);
        check_log;
        check_eq("wrap_ptr", reg_addr, 8'h01);

        // Wrong ID: nothing acknowledged or written, busy held until STOP
        oe_cnt = 0;
        m_start;
        m_wbyte(8'h60, a);
        check_eq("bad_id_nak", a, 1'b1);
        m_wbyte(8'h12, a);
        m_wbyte(8'h34, a);
        check_eq("bad_id_busy", busy, 1'b1);
        m_stop;
        check_eq("bad_id_oe_never", oe_cnt, 0);
        check_eq("bad_id_busy_drop", busy, 1'b0);
        check_log;

        // STOP after 4 data bits: single error pulse, no write
        err_cnt = 0;
        m_start;
        m_wbyte(8'h42, a);
        m_wbyte(8'h12, a);
        m_ptr = 8'h12;
        for (int i = 0; i < 4; i++) m_bit(1'b1, s, o);
        m_stop;
        check_eq("abort_err_once", err_cnt, 1);
        check_eq("abort_idle", busy, 1'b0);
        check_log;
        wd[0] = 8'h5A;
        do_write(8'h12, 1, 1'b1);
        check_log;

        // Reset while driving read data
        regfile[8'h20] = 8'h05;
        mem[8'h20]     = 8'h05;
        do_write(8'h20, 0, 1'b0);
        m_start;
        m_wbyte(8'h43, a);
        m_bit(1'b1, s, o);
        m_bit(1'b1, s, o);
        check_eq("rd_oe_before_rst", siod_oe, 1'b1);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_oe", siod_oe, 1'b0);
        check_eq("rst_mid_busy", busy, 1'b0);
        sda = 1'b1;
        sioc = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("rst_mid_addr", reg_addr, 8'h00);
        rst = 1'b0;
        m_ptr = 8'h00;
        #(4 * Q);
        check_log;
        wd[0] = 8'($urandom);
        do_write(8'h33, 1, 1'b1);
        check_log;
        do_write(8'h33, 0, 1'b0);
        do_read(1);
        check_log;

        // Randomized writes and write+read transactions
        err_cnt = 0;
        for (int t = 0; t < 30; t++) begin
            int n;
            n = $urandom_range(0, 3);
            for (int i = 0; i < 4; i++) wd[i] = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                do_write(8'($urandom), n, 1'b0);
                do_read($urandom_range(1, 3));
            end else begin
                do_write(8'($urandom), n, 1'b1);
            end
            check_log;
        end
        check_eq("rand_no_err", err_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
